// File: rtl/m3_steplencalc_pkg.sv
// Shared constants and state encoding for the m3 step-length calculator.
// Lengths are 22-bit clkI-cycle counts; the output port zero-extends them to 32 bits.
package m3_steplencalc_pkg;

   localparam int          LEN_W          = 22;
   localparam logic [21:0] LEN_START_DEF  = 22'd400000;
   localparam logic [21:0] LEN_MIN_DEF    = 22'd2000;
   localparam logic [21:0] TGT_STEP_DEF   = 22'd20000;
   localparam int          RAMP_SHIFT_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_HOLD     = 3'd1,
      ST_RAMP     = 3'd2,
      ST_STOPPING = 3'd3,
      ST_DONE     = 3'd4
   } state_e;

endpackage

// File: rtl/m3_steplencalc_reqedge.sv
// Two-input rising-edge detector; simultaneous rises cancel each other so a
// conflicting up/down request pair is dropped rather than arbitrated.
module m3_steplencalc_reqedge (
   input  logic clkI,
   input  logic nRstI,
   input  logic i_up,
   input  logic i_dn,
   output logic o_up,
   output logic o_dn
);

   logic r_up_d1, r_dn_d1;
   logic w_up_rise, w_dn_rise;

   always_ff @(posedge clkI or negedge nRstI) begin
      if (!nRstI) begin
         r_up_d1 <= 1'b0;
         r_dn_d1 <= 1'b0;
      end else begin
         r_up_d1 <= i_up;
         r_dn_d1 <= i_dn;
      end
   end

   assign w_up_rise = i_up & ~r_up_d1;
   assign w_dn_rise = i_dn & ~r_dn_d1;
   assign o_up      = w_up_rise & ~w_dn_rise;
   assign o_dn      = w_dn_rise & ~w_up_rise;

endmodule

// File: rtl/m3_steplencalc.sv
// Step-length calculator: turns INC/DEC requests into a target length and ramps the
// current length toward it one step per sequencer round; ramps back to start on forced stop.
module m3_steplencalc
   import m3_steplencalc_pkg::*;
#(
   parameter logic [21:0] LEN_START  = LEN_START_DEF,
   parameter logic [21:0] LEN_MIN    = LEN_MIN_DEF,
   parameter logic [21:0] TGT_STEP   = TGT_STEP_DEF,
   parameter int          RAMP_SHIFT = RAMP_SHIFT_DEF
) (
   input  logic        clkI,
   input  logic        nRstI,
   input  logic        m3startI,
   input  logic        m3forceStopI,
   input  logic        m3speedINCi,
   input  logic        m3speedDECi,
   input  logic        nextCalcI,
   output logic [31:0] dstRoundLenO,
   output logic        atTargetO,
   output logic        stoppedO
);

   state_e            r_state, w_state_nxt;
   logic [LEN_W-1:0]  r_cur, r_tgt, w_cur_nxt, w_tgt_nxt;
   logic              w_inc, w_dec;
   logic [LEN_W-1:0]  w_tgt_fast, w_tgt_slow, w_tgt_req;
   logic [LEN_W:0]    w_tgt_sum;
   logic [LEN_W-1:0]  w_ramp_tgt, w_shr, w_delta, w_dif, w_ramp;
   logic [LEN_W:0]    w_sum;

   m3_steplencalc_reqedge u_reqedge (
      .clkI  (clkI),
      .nRstI (nRstI),
      .i_up  (m3speedINCi),
      .i_dn  (m3speedDECi),
      .o_up  (w_inc),
      .o_dn  (w_dec)
   );

   // Target adjust with saturation at both ends of the legal length range
   assign w_tgt_fast = ({1'b0, r_tgt} >= ({1'b0, LEN_MIN} + {1'b0, TGT_STEP})) ?
                       (r_tgt - TGT_STEP) : LEN_MIN;
   assign w_tgt_sum  = {1'b0, r_tgt} + {1'b0, TGT_STEP};
   assign w_tgt_slow = (w_tgt_sum > {1'b0, LEN_START}) ? LEN_START : w_tgt_sum[LEN_W-1:0];

   always_comb begin
      w_tgt_req = r_tgt;
      if (w_inc)      w_tgt_req = w_tgt_fast;
      else if (w_dec) w_tgt_req = w_tgt_slow;
   end

   // A stop request coinciding with a ramp step already steers that step toward start speed
   assign w_ramp_tgt = (r_state == ST_STOPPING || m3forceStopI) ? LEN_START : r_tgt;
   assign w_shr      = r_cur >> RAMP_SHIFT;
   assign w_delta    = (w_shr == '0) ? {{(LEN_W-1){1'b0}}, 1'b1} : w_shr;
   assign w_dif      = r_cur - w_delta;
   assign w_sum      = {1'b0, r_cur} + {1'b0, w_delta};

   always_comb begin
      w_ramp = r_cur;
      if (r_cur > w_ramp_tgt)
         w_ramp = (w_dif < w_ramp_tgt) ? w_ramp_tgt : w_dif;
      else if (r_cur < w_ramp_tgt)
         w_ramp = (w_sum > {1'b0, w_ramp_tgt}) ? w_ramp_tgt : w_sum[LEN_W-1:0];
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cur_nxt   = r_cur;
      w_tgt_nxt   = r_tgt;
      if (!m3startI) begin
         w_state_nxt = ST_IDLE;
         w_cur_nxt   = LEN_START;
         w_tgt_nxt   = LEN_START;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!m3forceStopI) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
               if (m3forceStopI) begin
                  w_state_nxt = ST_STOPPING;
                  w_tgt_nxt   = LEN_START;
               end else if (w_tgt_req != r_tgt) begin
                  w_state_nxt = ST_RAMP;
                  w_tgt_nxt   = w_tgt_req;
               end
            end
            ST_RAMP: begin
               if (nextCalcI) w_cur_nxt = w_ramp;
               if (m3forceStopI) begin
                  w_state_nxt = ST_STOPPING;
                  w_tgt_nxt   = LEN_START;
               end else begin
                  // Settle against the updated target so a late request never strands HOLD off-target
                  w_tgt_nxt = w_tgt_req;
                  if ((nextCalcI ? w_ramp : r_cur) == w_tgt_req) w_state_nxt = ST_HOLD;
               end
            end
            ST_STOPPING: begin
               w_tgt_nxt = LEN_START;
               if (nextCalcI) begin
                  w_cur_nxt = w_ramp;
                  if (w_ramp == LEN_START) w_state_nxt = ST_DONE;
               end
            end
            ST_DONE: ;
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clkI or negedge nRstI) begin
      if (!nRstI) begin
         r_state <= ST_IDLE;
         r_cur   <= LEN_START;
         r_tgt   <= LEN_START;
      end else begin
         r_state <= w_state_nxt;
         r_cur   <= w_cur_nxt;
         r_tgt   <= w_tgt_nxt;
      end
   end

   assign dstRoundLenO = {10'd0, r_cur};
   assign atTargetO    = (r_cur == r_tgt);
   assign stoppedO     = (r_state == ST_DONE);

endmodule

// File: tb/tb_m3_steplencalc.sv
// Directed bench for m3_steplencalc: ramp-up, conflict drop, clamps, forced stop,
// start-low abort and asynchronous reset, all against hand-computed lengths.
module tb_m3_steplencalc;

   logic        clkI = 1'b0;
   logic        nRstI = 1'b1;
   logic        m3startI = 1'b0;
   logic        m3forceStopI = 1'b0;
   logic        m3speedINCi = 1'b0;
   logic        m3speedDECi = 1'b0;
   logic        nextCalcI = 1'b0;
   logic [31:0] dstRoundLenO;
   logic        atTargetO;
   logic        stoppedO;

   int n_vec = 0;
   int n_err = 0;

   m3_steplencalc dut (
      .clkI         (clkI),
      .nRstI        (nRstI),
      .m3startI     (m3startI),
      .m3forceStopI (m3forceStopI),
      .m3speedINCi  (m3speedINCi),
      .m3speedDECi  (m3speedDECi),
      .nextCalcI    (nextCalcI),
      .dstRoundLenO (dstRoundLenO),
      .atTargetO    (atTargetO),
      .stoppedO     (stoppedO)
   );

   always #5 clkI = ~clkI;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clkI);
      #1;
   endtask

   task automatic pulse_inc;
      m3speedINCi = 1'b1; tick;
      m3speedINCi = 1'b0; tick;
   endtask

   task automatic pulse_dec;
      m3speedDECi = 1'b1; tick;
      m3speedDECi = 1'b0; tick;
   endtask

   task automatic calc;
      nextCalcI = 1'b1; tick;
      nextCalcI = 1'b0;
   endtask

   int up_seq[5]   = '{375000, 351563, 329591, 308992, 300000};
   int stop_seq[5] = '{318750, 338671, 359837, 382326, 400000};

   initial begin
      int steps;
      // reset
      #2 nRstI = 1'b0;
      tick; tick;
      chk("rst_len", dstRoundLenO, 32'd400000);
      chk("rst_at", {31'd0, atTargetO}, 32'd1);
      chk("rst_stop", {31'd0, stoppedO}, 32'd0);
      nRstI = 1'b1;
      tick;

      // start -> HOLD, then 5 INC and ramp
      m3startI = 1'b1; tick;
      chk("start_len", dstRoundLenO, 32'd400000);
      chk("start_at", {31'd0, atTargetO}, 32'd1);
      chk("start_stop", {31'd0, stoppedO}, 32'd0);
      for (int i = 0; i < 5; i++) pulse_inc;
      chk("inc_nochange", dstRoundLenO, 32'd400000);
      chk("inc_at", {31'd0, atTargetO}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         calc;
         chk($sformatf("ramp%0d", i), dstRoundLenO, up_seq[i]);
         tick;
         chk($sformatf("ramp%0d_hold", i), dstRoundLenO, up_seq[i]);
      end
      chk("ramp_at", {31'd0, atTargetO}, 32'd1);

      // simultaneous INC and DEC rises are dropped
      m3speedINCi = 1'b1; m3speedDECi = 1'b1; tick;
      m3speedINCi = 1'b0; m3speedDECi = 1'b0; tick;
      chk("conflict_at", {31'd0, atTargetO}, 32'd1);
      calc;
      chk("conflict_len", dstRoundLenO, 32'd300000);

      // forced stop back to start speed
      m3forceStopI = 1'b1; tick;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("stop%0d_pre", i), {31'd0, stoppedO}, 32'd0);
         calc;
         chk($sformatf("stop%0d", i), dstRoundLenO, stop_seq[i]);
      end
      chk("stopped", {31'd0, stoppedO}, 32'd1);
      m3forceStopI = 1'b0; tick;
      chk("done_hold", {31'd0, stoppedO}, 32'd1);

      // restart, start low mid-RAMP, INC in IDLE ignored
      m3startI = 1'b0; tick;
      chk("idle_stop", {31'd0, stoppedO}, 32'd0);
      m3startI = 1'b1; tick;
      pulse_inc; pulse_inc;
      calc;
      chk("abort_ramp", dstRoundLenO, 32'd375000);
      m3startI = 1'b0; tick;
      chk("abort_len", dstRoundLenO, 32'd400000);
      chk("abort_at", {31'd0, atTargetO}, 32'd1);
      pulse_inc;
      calc;
      chk("idle_inc_len", dstRoundLenO, 32'd400000);
      m3startI = 1'b1; tick;
      calc;
      chk("hold_calc_len", dstRoundLenO, 32'd400000);
      chk("hold_calc_at", {31'd0, atTargetO}, 32'd1);

      // async reset while STOPPING
      pulse_inc; pulse_inc;
      calc;
      chk("pre_stop", dstRoundLenO, 32'd375000);
      m3forceStopI = 1'b1; tick;
      calc;
      chk("stopping_len", dstRoundLenO, 32'd398437);
      chk("stopping_flag", {31'd0, stoppedO}, 32'd0);
      #3 nRstI = 1'b0;
      #1;
      chk("arst_len", dstRoundLenO, 32'd400000);
      chk("arst_at", {31'd0, atTargetO}, 32'd1);
      chk("arst_stop", {31'd0, stoppedO}, 32'd0);
      m3forceStopI = 1'b0;
      tick; tick;
      nRstI = 1'b1;
      tick;

      // 30 INC: target clamps at LEN_MIN
      for (int i = 0; i < 30; i++) pulse_inc;
      calc;
      chk("clamp_first", dstRoundLenO, 32'd375000);
      steps = 0;
      while (!atTargetO && steps < 300) begin
         calc;
         steps++;
      end
      chk("clamp_reached", {31'd0, atTargetO}, 32'd1);
      chk("clamp_min", dstRoundLenO, 32'd2000);
      calc;
      chk("clamp_hold", dstRoundLenO, 32'd2000);

      // DEC from minimum: one ramp step of max(cur>>4,1)
      pulse_dec;
      chk("dec_at", {31'd0, atTargetO}, 32'd0);
      calc;
      chk("dec_len", dstRoundLenO, 32'd2125);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
